alu_muldiv_seq: RTL

//  Multi-cycle sequencer that implements MIPS MULTU/DIVU (unsigned) by driving the shared 32-bit alu iteratively.

---
 rtl/alu_muldiv_seq_pkg.sv | 17 +
 rtl/alu_muldiv_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   state_t  : sequencer state encoding
//   ALU_ADD  : alu control code for addition (shared with alu and main decoder)
//   ALU_SUB  : alu control code for subtraction
package alu_muldiv_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer. It borrows the shared 32-bit alu for
// one ADD or SUB per cycle: shift-add multiply, restoring divide, WIDTH iterations.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start_valid/start_ready    request handshake (ready only in IDLE)
//   op, opA, opB               0=MULTU 1=DIVU, operands (sampled on accept)
//   alu_srcA/srcB/ctrl         drive the external alu (quiescent when not iterating)
//   alu_res, alu_zero          combinational alu result / zero flag
//   done_valid/done_ready      result handshake
//   hi, lo, div_by_zero        result pair and divide-by-zero flag
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for a request, alu quiescent
// MUL     | shift-add multiply iteration, alu does ADD
// DIV     | restoring divide iteration, alu does SUB
// DONE    | result held until the consumer accepts it
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] alu_srcA,
  output logic [WIDTH-1:0] alu_srcB,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;  // multiplicand in MUL, divisor in DIV
  logic             r_dbz;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sh;
  logic             w_carry;
  logic             w_ge;

  assign w_accept = start_valid && start_ready;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_sh     = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  // Unsigned add overflowed iff the sum wrapped below an addend.
  assign w_carry  = (alu_res < r_hi);
  // With a nonzero divisor, sh - dvsr wraps above sh exactly when sh < dvsr,
  // so the subtract's own result gives the compare; zero covers sh == dvsr.
  assign w_ge     = r_hi[WIDTH-1] || alu_zero || (alu_res < w_sh);

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!op)            w_state_nxt = ST_MUL;
          else if (opB == '0) w_state_nxt = ST_DONE;
          else                w_state_nxt = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:        if (done_ready) w_state_nxt = ST_IDLE;
      default:        w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    start_ready = (r_state == ST_IDLE);
    done_valid  = (r_state == ST_DONE);
    alu_ctrl    = ALU_ADD;
    alu_srcA    = '0;
    alu_srcB    = '0;
    unique case (r_state)
      ST_MUL: begin
        alu_srcA = r_hi;
        alu_srcB = r_opnd;
      end
      ST_DIV: begin
        alu_ctrl = ALU_SUB;
        alu_srcA = w_sh;
        alu_srcB = r_opnd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
      r_dbz  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            if (!op) begin
              r_hi   <= '0;
              r_lo   <= opB;
              r_opnd <= opA;
              r_dbz  <= 1'b0;
            end else if (opB == '0) begin
              r_hi  <= opA;
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end else begin
              r_hi   <= '0;
              r_lo   <= opA;
              r_opnd <= opB;
              r_dbz  <= 1'b0;
            end
          end
        end
        ST_MUL: begin
          r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
          if (r_lo[0]) {r_hi, r_lo} <= {w_carry, alu_res, r_lo[WIDTH-1:1]};
          else         {r_hi, r_lo} <= {1'b0, r_hi, r_lo[WIDTH-1:1]};
        end
        ST_DIV: begin
          r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
          if (w_ge) begin
            r_hi <= alu_res;
            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
          end else begin
            r_hi <= w_sh;
            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
